// File: rtl/contrast_stretch_map.sv
// contrast_stretch_map
// Second pass of the contrast-stretching pipeline. Latches the frame min/max
// on start, derives a fixed-point scale factor with a restoring divider, then
// streams the source frame through a three-stage map pipeline into the
// destination frame RAM.
//
// Ports:
//   clk_i_stretch      clock, all logic on the rising edge
//   rst_i_stretch      synchronous active-high reset
//   start_i_stretch    start pulse (min/max done); ignored unless IDLE
//   min_i_stretch      frame minimum, sampled with start
//   max_i_stretch      frame maximum, sampled with start
//   rd_en_o_stretch    source RAM read enable
//   rd_addr_o_stretch  source RAM read address
//   rd_data_i_stretch  source pixel, valid one cycle after rd_en
//   wr_en_o_stretch    destination RAM write enable
//   wr_addr_o_stretch  destination RAM write address
//   wr_data_o_stretch  remapped pixel
//   busy_o_stretch     high whenever not IDLE
//   done_o_stretch     one-cycle pulse after the last write
module contrast_stretch_map #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 76800,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk_i_stretch,
  input  logic                  rst_i_stretch,
  input  logic                  start_i_stretch,
  input  logic [DATA_WIDTH-1:0] min_i_stretch,
  input  logic [DATA_WIDTH-1:0] max_i_stretch,
  output logic                  rd_en_o_stretch,
  output logic [ADDR_WIDTH-1:0] rd_addr_o_stretch,
  input  logic [DATA_WIDTH-1:0] rd_data_i_stretch,
  output logic                  wr_en_o_stretch,
  output logic [ADDR_WIDTH-1:0] wr_addr_o_stretch,
  output logic [DATA_WIDTH-1:0] wr_data_o_stretch,
  output logic                  busy_o_stretch,
  output logic                  done_o_stretch
);

  localparam int QW  = DATA_WIDTH + FRAC_BITS;      // scale factor width
  localparam int PW  = 2 * DATA_WIDTH + FRAC_BITS;  // product width
  localparam int DCW = $clog2(QW);

  localparam logic [QW-1:0]         NUMER     = {{DATA_WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] PIX_MAX   = '1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [DCW-1:0]        LAST_STEP = DCW'(QW - 1);
  localparam logic [PW:0]           ROUND     = (PW+1)'(1) << (FRAC_BITS - 1);

  typedef enum logic [2:0] {IDLE, DIV, STREAM, FLUSH, DONE} state_t;

  state_t state_q, state_d;

  // Control registers (reset)
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  s1_valid, s2_valid;

  // Datapath registers (no reset)
  logic [DATA_WIDTH-1:0] min_q, max_q, range_q;
  logic                  identity_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [QW-1:0]         numer_q;
  logic [QW-1:0]         scale_q;
  logic [DCW-1:0]        div_cnt;

  logic [ADDR_WIDTH-1:0] s1_addr, s2_addr;
  logic [DATA_WIDTH-1:0] s2_pix;
  logic                  s2_lo, s2_hi;
  logic [PW-1:0]         s2_prod;

  // Combinational helpers
  logic                  accept;
  logic [DATA_WIDTH:0]   trial;
  logic                  trial_ge;
  logic [DATA_WIDTH-1:0] s1_pix, s1_diff;
  logic                  s1_lo, s1_hi;
  logic [PW:0]           rounded;
  logic [PW:0]           shifted;
  logic [DATA_WIDTH-1:0] mapped, s3_result;

  assign accept = (state_q == IDLE) && start_i_stretch;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i_stretch) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its sources, independent of block order.
    if (rst_i_stretch) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d           = state_q;
    busy_o_stretch    = (state_q != IDLE);
    done_o_stretch    = (state_q == DONE);
    rd_en_o_stretch   = (state_q == STREAM);
    rd_addr_o_stretch = rd_cnt;
    unique case (state_q)
      IDLE:   if (start_i_stretch)
                state_d = (max_i_stretch > min_i_stretch) ? DIV : STREAM;
      DIV:    if (div_cnt == LAST_STEP) state_d = STREAM;
      STREAM: if (rd_cnt == LAST_ADDR) state_d = FLUSH;
      // The last pixel is on the write port this cycle; done follows it.
      FLUSH:  if (wr_en_o_stretch && (wr_addr_o_stretch == LAST_ADDR)) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame parameters and restoring divider: scale = floor(NUMER / range)
  // ---------------------------------------------------------------------------
  // Bring down the next numerator bit; range fits DATA_WIDTH bits so the
  // partial remainder never needs more than DATA_WIDTH+1.
  assign trial    = {rem_q, numer_q[QW-1]};
  assign trial_ge = (trial >= {1'b0, range_q});

  // NOTE: frame parameters, divider and pipeline data carry no reset; only
  // the valid bits and visible outputs need a defined value after reset.
  always_ff @(posedge clk_i_stretch) begin
    if (accept) begin
      min_q      <= min_i_stretch;
      max_q      <= max_i_stretch;
      range_q    <= max_i_stretch - min_i_stretch;
      identity_q <= !(max_i_stretch > min_i_stretch);
      rem_q      <= '0;
      numer_q    <= NUMER;
      scale_q    <= '0;
      div_cnt    <= '0;
    end else if (state_q == DIV) begin
      rem_q   <= trial_ge ? DATA_WIDTH'(trial - {1'b0, range_q}) : trial[DATA_WIDTH-1:0];
      scale_q <= {scale_q[QW-2:0], trial_ge};
      numer_q <= numer_q << 1;
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Map pipeline
  // S1: tag (valid/address) aligned with the RAM's registered read data;
  //     the pixel register is the source RAM output itself.
  // S2: flags and product.  S3: result onto the write port.
  // ---------------------------------------------------------------------------
  assign s1_pix  = rd_data_i_stretch;
  assign s1_lo   = (s1_pix <= min_q);
  assign s1_hi   = (s1_pix >= max_q);
  assign s1_diff = s1_pix - min_q;

  always_ff @(posedge clk_i_stretch) begin
    s1_addr <= rd_cnt;
    s2_addr <= s1_addr;
    s2_pix  <= s1_pix;
    s2_lo   <= s1_lo;
    s2_hi   <= s1_hi;
    // Clamped pixels skip the multiply; their product is never used.
    s2_prod <= (s1_lo || s1_hi) ? '0 : PW'(s1_diff) * PW'(scale_q);
  end

  assign rounded = {1'b0, s2_prod} + ROUND;
  assign shifted = rounded >> FRAC_BITS;
  assign mapped  = (|shifted[PW:DATA_WIDTH]) ? PIX_MAX : shifted[DATA_WIDTH-1:0];

  always_comb begin
    s3_result = mapped;
    if (identity_q)  s3_result = s2_pix;
    else if (s2_hi)  s3_result = PIX_MAX;
    else if (s2_lo)  s3_result = '0;
  end

  always_ff @(posedge clk_i_stretch) begin
    if (rst_i_stretch) begin
      rd_cnt            <= '0;
      s1_valid          <= 1'b0;
      s2_valid          <= 1'b0;
      wr_en_o_stretch   <= 1'b0;
      wr_addr_o_stretch <= '0;
      wr_data_o_stretch <= '0;
    end else begin
      if (state_q == STREAM)
        rd_cnt <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + 1'b1;
      s1_valid        <= rd_en_o_stretch;
      s2_valid        <= s1_valid;
      wr_en_o_stretch <= s2_valid;
      if (s2_valid) begin
        wr_addr_o_stretch <= s2_addr;
        wr_data_o_stretch <= s3_result;
      end
    end
  end

endmodule

// File: tb/tb_contrast_stretch_map.sv
// Self-checking bench for contrast_stretch_map (RAM_DEPTH=256).
// A scoreboard queues the expected write for every read the DUT issues and
// compares address, data and latency when the write appears; a vector table
// of hand-computed pixel mappings is checked against the destination RAM.
module tb_contrast_stretch_map;

  localparam int DW    = 8;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] mn_in, mx_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy, done;

  always #5 clk = ~clk;

  contrast_stretch_map #(
    .DATA_WIDTH(DW), .RAM_DEPTH(DEPTH), .FRAC_BITS(8)
  ) dut (
    .clk_i_stretch    (clk),
    .rst_i_stretch    (rst),
    .start_i_stretch  (start),
    .min_i_stretch    (mn_in),
    .max_i_stretch    (mx_in),
    .rd_en_o_stretch  (rd_en),
    .rd_addr_o_stretch(rd_addr),
    .rd_data_i_stretch(rd_data),
    .wr_en_o_stretch  (wr_en),
    .wr_addr_o_stretch(wr_addr),
    .wr_data_o_stretch(wr_data),
    .busy_o_stretch   (busy),
    .done_o_stretch   (done)
  );

  // Source / destination RAM models
  logic [DW-1:0] src [DEPTH];
  logic [DW-1:0] dst [DEPTH];
  always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, required %0d", name, cyc, act, req);
    end
  endtask

  // Reference mapping, straight from the pixel formula
  function automatic logic [DW-1:0] model(input logic [DW-1:0] p, input logic [DW-1:0] mn,
                                          input logic [DW-1:0] mx);
    int scale, v;
    if (mx <= mn) return p;
    if (p >= mx)  return 8'd255;
    if (p <= mn)  return 8'd0;
    scale = 65280 / (int'(mx) - int'(mn));
    v = ((int'(p) - int'(mn)) * scale + 128) / 256;
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  // Scoreboard
  typedef struct {
    int            addr;
    int            due;
    logic [DW-1:0] exp;
  } sb_t;
  sb_t sbq[$];
  sb_t sb_e;

  logic [DW-1:0] cur_min, cur_max;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rd_en)
      sbq.push_back('{addr: int'(rd_addr), due: cyc + 3, exp: model(src[rd_addr], cur_min, cur_max)});
    if (wr_en) begin
      dst[wr_addr] = wr_data;
      if (sbq.size() == 0) begin
        check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        sb_e = sbq.pop_front();
        check("wr_addr",    32'(wr_addr), 32'(sb_e.addr));
        check("wr_data",    32'(wr_data), 32'(sb_e.exp));
        check("wr_latency", 32'(cyc),     32'(sb_e.due));
      end
    end
  end

  function automatic logic [31:0] outs();
    return 32'({rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done});
  endfunction

  // One frame: start pulse at a negedge, then bounded wait for done.
  task automatic run_frame(input logic [DW-1:0] mn, input logic [DW-1:0] mx, input bit restart);
    int s, rel, first_rd;
    bit ident, seen;
    ident    = !(mx > mn);
    cur_min  = mn;
    cur_max  = mx;
    done_cnt = 0;
    first_rd = 0;
    seen     = 0;
    foreach (dst[i]) dst[i] = 'x;
    start = 1'b1; mn_in = mn; mx_in = mx;
    @(negedge clk);
    s = cyc;                 // this is cycle 1
    start = 1'b0; mn_in = '0; mx_in = '0;
    check("busy_cycle1", 32'(busy), 32'd1);
    if (rd_en) first_rd = 1;
    for (int k = 0; k < DEPTH + 60 && !seen; k++) begin
      @(negedge clk);
      rel = cyc - s + 1;
      start = 1'b0;
      if (restart && rel == 4) begin   // sampled at the start of cycle 5, inside DIV
        start = 1'b1; mn_in = 8'd0; mx_in = 8'd10;
      end
      if (rd_en && first_rd == 0) first_rd = rel;
      if (done) begin
        seen = 1;
        check("done_cycle", 32'(rel), ident ? 32'(DEPTH + 4) : 32'(DEPTH + 20));
      end
    end
    start = 1'b0;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    check("first_read_cycle", 32'(first_rd), ident ? 32'd1 : 32'd17);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("sb_drained",  32'(sbq.size()), 32'd0);
  endtask

  typedef struct {
    logic [DW-1:0] mn, mx;
    int            addr;
    logic [DW-1:0] pix, exp;
  } vec_t;
  vec_t tbl[$];

  logic [DW-1:0] fr_mn [4];
  logic [DW-1:0] fr_mx [4];
  int            n_wait;

  initial begin
    // Hand-computed vectors (scale for 50/200 is 435)
    tbl.push_back('{8'd50,  8'd200, 0,   8'd50,  8'd0});
    tbl.push_back('{8'd50,  8'd200, 1,   8'd125, 8'd127});
    tbl.push_back('{8'd50,  8'd200, 2,   8'd200, 8'd255});
    tbl.push_back('{8'd50,  8'd200, 3,   8'd30,  8'd0});
    tbl.push_back('{8'd50,  8'd200, 4,   8'd255, 8'd255});
    tbl.push_back('{8'd50,  8'd200, 5,   8'd51,  8'd2});
    tbl.push_back('{8'd50,  8'd200, 6,   8'd199, 8'd253});
    tbl.push_back('{8'd50,  8'd200, 7,   8'd100, 8'd85});
    tbl.push_back('{8'd100, 8'd100, 0,   8'd100, 8'd100});
    tbl.push_back('{8'd100, 8'd100, 255, 8'd100, 8'd100});
    tbl.push_back('{8'd255, 8'd0,   0,   8'd77,  8'd77});
    tbl.push_back('{8'd255, 8'd0,   1,   8'd0,   8'd0});
    tbl.push_back('{8'd255, 8'd0,   2,   8'd255, 8'd255});
    tbl.push_back('{8'd0,   8'd255, 0,   8'd0,   8'd0});
    tbl.push_back('{8'd0,   8'd255, 1,   8'd1,   8'd1});
    tbl.push_back('{8'd0,   8'd255, 128, 8'd128, 8'd128});
    tbl.push_back('{8'd0,   8'd255, 255, 8'd255, 8'd255});

    fr_mn[0] = 8'd50;  fr_mx[0] = 8'd200;   // nominal stretch
    fr_mn[1] = 8'd100; fr_mx[1] = 8'd100;   // flat frame
    fr_mn[2] = 8'd255; fr_mx[2] = 8'd0;     // invalid range
    fr_mn[3] = 8'd0;   fr_mx[3] = 8'd255;   // full range

    cur_min = '0; cur_max = '0;
    rst = 1'b1; start = 1'b0; mn_in = '0; mx_in = '0;
    foreach (src[i]) src[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), 32'd0);

    for (int f = 0; f < 4; f++) begin
      foreach (src[i]) begin
        if (f == 1)      src[i] = 8'd100;
        else if (f == 3) src[i] = 8'(i);
        else             src[i] = 8'($urandom_range(0, 255));
      end
      foreach (tbl[i])
        if (tbl[i].mn == fr_mn[f] && tbl[i].mx == fr_mx[f]) src[tbl[i].addr] = tbl[i].pix;
      run_frame(fr_mn[f], fr_mx[f], 1'b0);
      foreach (tbl[i])
        if (tbl[i].mn == fr_mn[f] && tbl[i].mx == fr_mx[f])
          check("vector", 32'(dst[tbl[i].addr]), 32'(tbl[i].exp));
      if (f == 3)
        for (int k = 0; k < DEPTH; k++) check("full_range", 32'(dst[k]), 32'(k));
    end

    // Re-start inside DIV is dropped
    foreach (src[i]) src[i] = 8'($urandom_range(0, 255));
    run_frame(8'd50, 8'd200, 1'b1);

    // Reset mid-stream at read address 7
    cur_min = 8'd20; cur_max = 8'd220;
    foreach (src[i]) src[i] = 8'($urandom_range(0, 255));
    start = 1'b1; mn_in = 8'd20; mx_in = 8'd220;
    @(negedge clk);
    start = 1'b0;
    n_wait = 0;
    while (!(rd_en && rd_addr == 8'd7) && n_wait < 100) begin
      @(negedge clk);
      n_wait++;
    end
    check("reach_addr7", 32'(n_wait < 100), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_outputs", outs(), 32'd0);
    rst = 1'b0;
    sbq.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_reset_quiet", outs(), 32'd0);
    end
    run_frame(8'd20, 8'd220, 1'b0);
    check("after_reset_addr0", 32'(dst[0]), 32'(model(src[0], 8'd20, 8'd220)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/contrast_stretch_map.md
# contrast_stretch_map

Second pass of the contrast-stretching pipeline. It sits directly downstream of the min/max finder. It latches the frame minimum and maximum when that stage signals done, then computes a fixed-point scale factor with a sequential divider. It then streams every pixel from the source frame RAM, remaps each one to `(pix - min) * (2^DATA_WIDTH - 1) / (max - min)`, and writes the result to the destination frame RAM.

## Interface
Parameters:
- `DATA_WIDTH`, 8: pixel width.
- `RAM_DEPTH`, 76800: pixels per frame (320x240).
- `ADDR_WIDTH`, `$clog2(RAM_DEPTH)`: RAM address width.
- `FRAC_BITS`, 8: fractional bits of the scale factor.

Ports:
- `clk_i_stretch` in 1: clock. Single clock domain; all logic on the rising edge.
- `rst_i_stretch` in 1: reset, synchronous, active-high.
- `start_i_stretch` in 1: start pulse, driven by the min/max done pulse. Ignored unless in IDLE.
- `min_i_stretch` in DATA_WIDTH: frame minimum, sampled on the start cycle.
- `max_i_stretch` in DATA_WIDTH: frame maximum, sampled on the start cycle.
- `rd_en_o_stretch` out 1: source RAM read enable.
- `rd_addr_o_stretch` out ADDR_WIDTH: source RAM read address.
- `rd_data_i_stretch` in DATA_WIDTH: source pixel, valid exactly 1 cycle after `rd_en_o_stretch`.
- `wr_en_o_stretch` out 1: destination RAM write enable.
- `wr_addr_o_stretch` out ADDR_WIDTH: destination write address.
- `wr_data_o_stretch` out DATA_WIDTH: remapped pixel.
- `busy_o_stretch` out 1: high whenever state ≠ IDLE.
- `done_o_stretch` out 1: one-cycle pulse after the last write.

## Operation
- States: IDLE, DIV, STREAM, FLUSH, DONE.
- IDLE:
  - When `start_i_stretch`=1, latch min and max and compute `range = max - min`.
  - If max > min, set identity=0 and go to DIV.
  - Otherwise (flat or invalid frame, including min=255/max=0), set identity=1 and go to STREAM.
- DIV: restoring divider.
  - Numerator is `(2^DATA_WIDTH - 1) << FRAC_BITS`; divisor is `range`.
  - Produces one quotient bit per cycle, DATA_WIDTH+FRAC_BITS cycles in total (16 by default).
  - `scale = floor(numerator / range)`, width DATA_WIDTH+FRAC_BITS.
  - Go to STREAM when the divider completes.
- STREAM: issue one read per cycle, addresses 0 to RAM_DEPTH-1, no gaps. After issuing address RAM_DEPTH-1, go to FLUSH.
- Map pipeline, three registered stages per pixel. Each stage carries a valid bit and the pixel's address.
  - S1: register `pix` from `rd_data_i_stretch` and the flags `lo = (pix <= min)` and `hi = (pix >= max)`.
  - S2: product `(pix - min) * scale`, width 2*DATA_WIDTH+FRAC_BITS. Only evaluated when neither `lo` nor `hi` is set.
  - S3: result, registered onto the write port.
    - identity=1: pix.
    - `hi`: 2^DATA_WIDTH-1.
    - `lo`: 0.
    - Otherwise: `(product + 2^(FRAC_BITS-1)) >> FRAC_BITS`, saturated to 2^DATA_WIDTH-1.
  - `hi` takes priority over `lo`; the two coincide only when identity=1.
- FLUSH: wait until the S3 valid bit for address RAM_DEPTH-1 has produced its write, then go to DONE.
- DONE: `done_o_stretch`=1 for one cycle, then go to IDLE.
- Reset, including mid-frame:
  - State returns to IDLE and all pipeline valid bits clear.
  - Every output is 0 from the cycle after reset is sampled; no further writes occur.
  - Latched min, max and scale are don't-care.
- A `start_i_stretch` arriving in any state other than IDLE is dropped; nothing is queued.

## Timing
- Reset values: `rd_en_o_stretch`, `rd_addr_o_stretch`, `wr_en_o_stretch`, `wr_addr_o_stretch`, `wr_data_o_stretch`, `busy_o_stretch` and `done_o_stretch` are all 0.
- Cycle 0 is the edge at which start is sampled. From then on:
  - Stretch case: `busy_o_stretch`=1 from cycle 1. DIV runs cycles 1-16. First read (address 0) is in cycle 17, last read in cycle 16+RAM_DEPTH.
  - Identity case: first read is in cycle 1.
- Write latency: a read issued in cycle t appears on the write port in cycle t+3, with `wr_addr_o_stretch` equal to that read address. Writes are then continuous, one per cycle.
- Done timing: `done_o_stretch` is high in the cycle after the last write. `busy_o_stretch` falls the cycle after done.
  - Stretch case: done at cycle RAM_DEPTH+20.
  - Identity case: done at cycle RAM_DEPTH+4.
- Start may be issued again in the first cycle `busy_o_stretch`=0.

## Test plan
- **Nominal stretch.** RAM_DEPTH=16, min=50, max=200, so scale=435.
  - Pixels 50, 125, 200, 30, 255 → writes 0, 127, 255, 0, 255.
  - Writes land at matching addresses, 3 cycles after their reads. Done pulses at cycle 36.
- **Flat frame.** min=max=100, all pixels 100.
  - No DIV state is entered. Every write is 100. Done pulses at cycle 20.
- **Invalid range.** min=255, max=0 (empty-frame defaults).
  - Identity path is taken and the output equals the input at every address.
- **Full-range check.** min=0, max=255, so scale=256.
  - Pixel k → k for all 0..255 with RAM_DEPTH=256, with no rounding drift.
- **Re-start ignored.** Start pulses again at cycle 5, inside DIV.
  - No effect: single frame pass, single done pulse, min/max unchanged.
- **Reset mid-stream.** Assert `rst_i_stretch` during STREAM at address 7.
  - All outputs are 0 from the next cycle, and no writes follow.
  - A subsequent start runs a full frame correctly from address 0.
